// File: rtl/parallel_recv_check.sv
// parallel_recv_check: receive-side word aligner and test-sequence checker.
// Finds the bit offset of the word-align marker in a possibly rotated raw
// stream, then forwards aligned words and checks the incrementing sequence.
module parallel_recv_check #(
  parameter logic [31:0] ALIGN_PAT      = 32'h0000F731,
  parameter logic [31:0] TRAIN_PAT      = 32'h0000AAAA,
  parameter int unsigned ALIGN_HITS     = 2,
  parameter int unsigned MAX_CONSEC_ERR = 4,
  parameter int unsigned ERR_CNT_W      = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 CLR,
  input  logic                 DIVALID,
  input  logic [31:0]          DIN,
  output logic                 DOPUSH,
  output logic [31:0]          DOUT,
  output logic                 LOCKED,
  output logic [4:0]           BIT_OFFSET,
  output logic                 ERR,
  output logic [ERR_CNT_W-1:0] ERR_CNT,
  output logic [31:0]          GOOD_CNT
);

  typedef enum logic [1:0] {HUNT, CONFIRM, WORD_LOCK, CHECK} state_t;

  localparam logic [3:0] HITS_REQ = 4'(ALIGN_HITS);
  localparam logic [3:0] ERR_MAX  = 4'(MAX_CONSEC_ERR);

  state_t                 state, state_nxt;
  logic                   rst_any;

  logic [31:0]            prev;
  logic                   have_prev;
  logic [4:0]             cand, cand_nxt;
  logic [3:0]             hit_cnt, hit_nxt;
  logic [4:0]             off_q, off_nxt;
  logic [3:0]             consec, consec_nxt;
  logic [31:0]            expected, exp_nxt;

  logic [31:0]            dout_q;
  logic                   dopush_q;
  logic                   err_q;
  logic [ERR_CNT_W-1:0]   err_cnt_q;
  logic [31:0]            good_cnt_q;

  logic [63:0]            win;
  logic [31:0]            a_cand;
  logic [31:0]            a_lock;
  logic                   hunt_hit;
  logic [4:0]             hunt_k;
  logic                   do_push;
  logic                   do_good;
  logic                   do_bad;

  assign rst_any = RST | CLR;

  // Sliding 64-bit window and the candidate / locked alignments out of it.
  always_comb begin
    win    = {DIN, prev};
    a_cand = 32'(win >> cand);
    a_lock = 32'(win >> off_q);
  end

  // Marker search across all 32 offsets; lowest matching offset wins.
  always_comb begin
    hunt_hit = 1'b0;
    hunt_k   = '0;
    for (int unsigned k = 0; k < 32; k++) begin
      if (!hunt_hit && (32'(win >> k) == ALIGN_PAT)) begin
        hunt_hit = 1'b1;
        hunt_k   = 5'(k);
      end
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (rst_any) state <= HUNT;
    else         state <= state_nxt;
  end

  // Next-state and per-word actions; nothing moves without a complete window.
  always_comb begin
    state_nxt  = state;
    cand_nxt   = cand;
    hit_nxt    = hit_cnt;
    off_nxt    = off_q;
    consec_nxt = consec;
    exp_nxt    = expected;
    do_push    = 1'b0;
    do_good    = 1'b0;
    do_bad     = 1'b0;
    if (DIVALID && have_prev) begin
      unique case (state)
        HUNT: begin
          if (hunt_hit) begin
            cand_nxt = hunt_k;
            hit_nxt  = 4'd1;
            if (HITS_REQ == 4'd1) begin
              off_nxt   = hunt_k;
              state_nxt = WORD_LOCK;
            end else begin
              state_nxt = CONFIRM;
            end
          end
        end
        CONFIRM: begin
          if (a_cand == ALIGN_PAT) begin
            hit_nxt = hit_cnt + 4'd1;
            if (hit_nxt == HITS_REQ) begin
              off_nxt   = cand;
              state_nxt = WORD_LOCK;
            end
          end else begin
            hit_nxt   = '0;
            state_nxt = HUNT;
          end
        end
        WORD_LOCK: begin
          if (a_lock == ALIGN_PAT) begin
            state_nxt = WORD_LOCK;
          end else if ((a_lock == TRAIN_PAT) || (a_lock == '0)) begin
            state_nxt = HUNT;
          end else begin
            do_push    = 1'b1;
            do_good    = 1'b1;
            exp_nxt    = a_lock + 32'd1;
            consec_nxt = '0;
            state_nxt  = CHECK;
          end
        end
        CHECK: begin
          // The expected-value match is tested first so a wrap to zero is data.
          if (a_lock == expected) begin
            do_push    = 1'b1;
            do_good    = 1'b1;
            exp_nxt    = expected + 32'd1;
            consec_nxt = '0;
          end else if ((a_lock == TRAIN_PAT) || (a_lock == '0)) begin
            state_nxt = HUNT;
          end else begin
            do_push    = 1'b1;
            do_bad     = 1'b1;
            exp_nxt    = a_lock + 32'd1;
            consec_nxt = consec + 4'd1;
            if (consec_nxt == ERR_MAX) state_nxt = HUNT;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  // Datapath registers, strobes and saturating counters.
  always_ff @(posedge CLK) begin
    if (rst_any) begin
      prev       <= '0;
      have_prev  <= 1'b0;
      cand       <= '0;
      hit_cnt    <= '0;
      off_q      <= '0;
      consec     <= '0;
      expected   <= '0;
      dout_q     <= '0;
      dopush_q   <= 1'b0;
      err_q      <= 1'b0;
      err_cnt_q  <= '0;
      good_cnt_q <= '0;
    end else begin
      dopush_q <= do_push;
      err_q    <= do_bad;
      cand     <= cand_nxt;
      hit_cnt  <= hit_nxt;
      off_q    <= off_nxt;
      consec   <= consec_nxt;
      expected <= exp_nxt;
      if (DIVALID) begin
        prev      <= DIN;
        have_prev <= 1'b1;
      end
      if (do_push) dout_q <= a_lock;
      if (do_good && (good_cnt_q != '1)) good_cnt_q <= good_cnt_q + 32'd1;
      if (do_bad && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
  end

  // Output drive; lock status follows the registered state.
  always_comb begin
    DOPUSH     = dopush_q;
    DOUT       = dout_q;
    LOCKED     = (state == WORD_LOCK) || (state == CHECK);
    BIT_OFFSET = off_q;
    ERR        = err_q;
    ERR_CNT    = err_cnt_q;
    GOOD_CNT   = good_cnt_q;
  end

endmodule

// File: tb/tb_parallel_recv_check.sv
// Directed bench for parallel_recv_check: lock, rotation, corruption,
// loss of lock, false marker, clear and sequence wrap.
module tb_parallel_recv_check;

  localparam logic [31:0] AP = 32'h0000F731;
  localparam logic [31:0] TP = 32'h0000AAAA;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        CLR = 1'b0;
  logic        DIVALID = 1'b0;
  logic [31:0] DIN = '0;
  logic        DOPUSH;
  logic [31:0] DOUT;
  logic        LOCKED;
  logic [4:0]  BIT_OFFSET;
  logic        ERR;
  logic [15:0] ERR_CNT;
  logic [31:0] GOOD_CNT;

  int checks = 0;
  int errors = 0;
  int sh = 0;
  logic [31:0] prev_sent = '0;

  parallel_recv_check #(
    .ALIGN_PAT(AP), .TRAIN_PAT(TP), .ALIGN_HITS(2), .MAX_CONSEC_ERR(4), .ERR_CNT_W(16)
  ) dut (
    .CLK(CLK), .RST(RST), .CLR(CLR), .DIVALID(DIVALID), .DIN(DIN),
    .DOPUSH(DOPUSH), .DOUT(DOUT), .LOCKED(LOCKED), .BIT_OFFSET(BIT_OFFSET),
    .ERR(ERR), .ERR_CNT(ERR_CNT), .GOOD_CNT(GOOD_CNT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  // Send one word as the link would deliver it when delayed by sh bits.
  task automatic send(input logic [31:0] w);
    logic [63:0] t;
    t = {w, prev_sent};
    DIN = 32'(t >> (32 - sh));
    DIVALID = 1'b1;
    prev_sent = w;
    @(posedge CLK); #1;
    DIVALID = 1'b0;
  endtask

  task automatic idle();
    DIVALID = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic do_reset(input int s);
    RST = 1'b1; DIVALID = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    sh = s;
    prev_sent = '0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    if (DOPUSH !== 1'b0) begin errors++; $display("FAIL rst_dopush got %b exp 0", DOPUSH); end checks++;
    if (DOUT !== 32'd0) begin errors++; $display("FAIL rst_dout got %h exp 0", DOUT); end checks++;
    if (LOCKED !== 1'b0) begin errors++; $display("FAIL rst_locked got %b exp 0", LOCKED); end checks++;
    if (BIT_OFFSET !== 5'd0) begin errors++; $display("FAIL rst_offset got %0d exp 0", BIT_OFFSET); end checks++;
    if (ERR !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", ERR); end checks++;
    if (ERR_CNT !== 16'd0) begin errors++; $display("FAIL rst_errcnt got %0d exp 0", ERR_CNT); end checks++;
    if (GOOD_CNT !== 32'd0) begin errors++; $display("FAIL rst_goodcnt got %0d exp 0", GOOD_CNT); end checks++;
  endtask

  // Shared lock-and-data sequence for a given rotation.
  task automatic run_basic(input int s, input string tag);
    do_reset(s);
    repeat (4) send(TP);
    repeat (3) send(AP);
    send(32'd5);
    if (LOCKED !== 1'b1) begin errors++; $display("FAIL %s_locked got %b exp 1", tag, LOCKED); end checks++;
    if (BIT_OFFSET !== 5'(s)) begin errors++; $display("FAIL %s_offset got %0d exp %0d", tag, BIT_OFFSET, s); end checks++;
    if (DOPUSH !== 1'b0) begin errors++; $display("FAIL %s_nopush got %b exp 0", tag, DOPUSH); end checks++;
    send(32'd6);
    if (DOPUSH !== 1'b1 || DOUT !== 32'd5) begin errors++; $display("FAIL %s_d5 got push %b dout %h exp 1 5", tag, DOPUSH, DOUT); end checks++;
    idle();
    if (DOPUSH !== 1'b0 || LOCKED !== 1'b1 || GOOD_CNT !== 32'd1) begin
      errors++; $display("FAIL %s_idle got push %b lock %b good %0d exp 0 1 1", tag, DOPUSH, LOCKED, GOOD_CNT); end checks++;
    send(32'd7);
    if (DOPUSH !== 1'b1 || DOUT !== 32'd6) begin errors++; $display("FAIL %s_d6 got push %b dout %h exp 1 6", tag, DOPUSH, DOUT); end checks++;
    send(32'd8);
    if (DOUT !== 32'd7) begin errors++; $display("FAIL %s_d7 got %h exp 7", tag, DOUT); end checks++;
    send(TP);
    if (DOPUSH !== 1'b1 || DOUT !== 32'd8) begin errors++; $display("FAIL %s_d8 got push %b dout %h exp 1 8", tag, DOPUSH, DOUT); end checks++;
    if (GOOD_CNT !== 32'd4) begin errors++; $display("FAIL %s_good got %0d exp 4", tag, GOOD_CNT); end checks++;
    if (ERR_CNT !== 16'd0) begin errors++; $display("FAIL %s_errcnt got %0d exp 0", tag, ERR_CNT); end checks++;
    send(TP);
    if (LOCKED !== 1'b0 || DOPUSH !== 1'b0) begin errors++; $display("FAIL %s_unlock got lock %b push %b exp 0 0", tag, LOCKED, DOPUSH); end checks++;
  endtask

  task automatic test_lock_offset0();
    run_basic(0, "lock0");
  endtask

  task automatic test_rotated();
    run_basic(8, "rot8");
  endtask

  task automatic test_corruption();
    do_reset(13);
    send(TP);
    repeat (3) send(AP);
    send(32'd100);
    send(32'd101);
    if (DOUT !== 32'd100 || ERR !== 1'b0) begin errors++; $display("FAIL cor_d100 got dout %h err %b exp 64 0", DOUT, ERR); end checks++;
    send(32'h0000DEAD);
    send(32'd103);
    if (ERR !== 1'b1 || DOUT !== 32'h0000DEAD || ERR_CNT !== 16'd1) begin
      errors++; $display("FAIL cor_dead got err %b dout %h cnt %0d exp 1 dead 1", ERR, DOUT, ERR_CNT); end checks++;
    send(32'd104);
    if (ERR !== 1'b1 || DOUT !== 32'd103 || ERR_CNT !== 16'd2) begin
      errors++; $display("FAIL cor_103 got err %b dout %h cnt %0d exp 1 67 2", ERR, DOUT, ERR_CNT); end checks++;
    send(TP);
    if (ERR !== 1'b0 || DOPUSH !== 1'b1 || DOUT !== 32'd104) begin
      errors++; $display("FAIL cor_104 got err %b push %b dout %h exp 0 1 68", ERR, DOPUSH, DOUT); end checks++;
    if (LOCKED !== 1'b1 || GOOD_CNT !== 32'd3 || ERR_CNT !== 16'd2) begin
      errors++; $display("FAIL cor_state got lock %b good %0d err %0d exp 1 3 2", LOCKED, GOOD_CNT, ERR_CNT); end checks++;
  endtask

  task automatic test_loss_of_lock();
    do_reset(5);
    send(TP);
    repeat (3) send(AP);
    send(32'd10);
    send(32'd11);
    send(32'h12345678);
    if (DOUT !== 32'd11 || ERR !== 1'b0) begin errors++; $display("FAIL loss_d11 got dout %h err %b exp b 0", DOUT, ERR); end checks++;
    send(32'h9ABCDEF0);
    send(32'h0BADF00D);
    send(32'h13579BDF);
    if (LOCKED !== 1'b1 || ERR_CNT !== 16'd3) begin errors++; $display("FAIL loss_three got lock %b cnt %0d exp 1 3", LOCKED, ERR_CNT); end checks++;
    send(TP);
    if (ERR !== 1'b1 || ERR_CNT !== 16'd4) begin errors++; $display("FAIL loss_four got err %b cnt %0d exp 1 4", ERR, ERR_CNT); end checks++;
    if (LOCKED !== 1'b0) begin errors++; $display("FAIL loss_unlock got %b exp 0", LOCKED); end checks++;
  endtask

  task automatic test_false_marker();
    do_reset(3);
    send(TP);
    send(AP);
    send(32'h55667788);
    if (LOCKED !== 1'b0) begin errors++; $display("FAIL fm_onehit got %b exp 0", LOCKED); end checks++;
    send(AP);
    if (LOCKED !== 1'b0) begin errors++; $display("FAIL fm_broken got %b exp 0", LOCKED); end checks++;
    send(AP);
    send(32'h20);
    if (LOCKED !== 1'b1 || BIT_OFFSET !== 5'd3) begin
      errors++; $display("FAIL fm_lock got lock %b off %0d exp 1 3", LOCKED, BIT_OFFSET); end checks++;
    send(32'h21);
    if (DOPUSH !== 1'b1 || DOUT !== 32'h20) begin errors++; $display("FAIL fm_data got push %b dout %h exp 1 20", DOPUSH, DOUT); end checks++;
  endtask

  task automatic test_clr_wrap();
    do_reset(21);
    send(TP);
    repeat (3) send(AP);
    send(32'd5);
    send(32'd6);
    send(32'd7);
    if (LOCKED !== 1'b1 || BIT_OFFSET !== 5'd21 || DOUT !== 32'd6) begin
      errors++; $display("FAIL clr_pre got lock %b off %0d dout %h exp 1 21 6", LOCKED, BIT_OFFSET, DOUT); end checks++;
    CLR = 1'b1;
    @(posedge CLK); #1;
    CLR = 1'b0;
    if (DOPUSH !== 1'b0 || DOUT !== 32'd0 || LOCKED !== 1'b0 || BIT_OFFSET !== 5'd0 ||
        ERR !== 1'b0 || ERR_CNT !== 16'd0 || GOOD_CNT !== 32'd0) begin
      errors++; $display("FAIL clr_zero got push %b dout %h lock %b off %0d err %b ecnt %0d good %0d exp all 0",
                         DOPUSH, DOUT, LOCKED, BIT_OFFSET, ERR, ERR_CNT, GOOD_CNT); end checks++;
    send(TP);
    send(TP);
    repeat (3) send(AP);
    send(32'hFFFFFFFE);
    send(32'hFFFFFFFF);
    if (DOUT !== 32'hFFFFFFFE || LOCKED !== 1'b1) begin errors++; $display("FAIL wrap_fe got dout %h lock %b exp fffffffe 1", DOUT, LOCKED); end checks++;
    send(32'd0);
    send(32'd1);
    if (DOPUSH !== 1'b1 || DOUT !== 32'd0 || ERR !== 1'b0) begin
      errors++; $display("FAIL wrap_zero got push %b dout %h err %b exp 1 0 0", DOPUSH, DOUT, ERR); end checks++;
    send(TP);
    if (DOUT !== 32'd1 || GOOD_CNT !== 32'd4 || ERR_CNT !== 16'd0) begin
      errors++; $display("FAIL wrap_end got dout %h good %0d ecnt %0d exp 1 4 0", DOUT, GOOD_CNT, ERR_CNT); end checks++;
    send(TP);
    if (LOCKED !== 1'b0) begin errors++; $display("FAIL wrap_unlock got %b exp 0", LOCKED); end checks++;
  endtask

  initial begin
    test_reset();
    test_lock_offset0();
    test_rotated();
    test_corruption();
    test_loss_of_lock();
    test_false_marker();
    test_clr_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/parallel_recv_check.md
Name: parallel_recv_check

Overview:
- Receive-side checker directly downstream of the parallel link sender/deserializer path.
- Consumes raw 32-bit words that may be bit-rotated by the link, and finds the bit offset from the word-align pattern.
- Forwards aligned data words and verifies the incrementing test-data sequence the sender produces.
- Reports lock status, bit offset, error count and good-word count to the test controller.

Parameters:
- ALIGN_PAT, 32'h0000F731, word-align marker sent during the word-align phase.
- TRAIN_PAT, 32'h0000AAAA, delay-adjust training word.
- ALIGN_HITS, 2, consecutive marker hits at the same offset required to lock (1..15).
- MAX_CONSEC_ERR, 4, consecutive data mismatches that drop lock (1..15).
- ERR_CNT_W, 16, error counter width.

Ports:
- CLK  in  1  clock; single clock domain.
- RST  in  1  synchronous, active-high reset.
- CLR  in  1  synchronous clear; same effect as RST.
- DIVALID  in  1  DIN valid this cycle.
- DIN  in  32  raw received word; stream is LSB-first, possibly delayed by s bits (0..31).
- DOPUSH  out  1  DOUT valid; one-cycle strobe per checked data word.
- DOUT  out  32  aligned data word.
- LOCKED  out  1  high in WORD_LOCK and CHECK.
- BIT_OFFSET  out  5  selected offset k.
- ERR  out  1  one-cycle pulse per counted mismatch.
- ERR_CNT  out  ERR_CNT_W  mismatch count; saturates at all-ones.
- GOOD_CNT  out  32  matched-word count; saturates at all-ones.

Behaviour:
- **Reset values.** RST or CLR (CLR has equal priority to RST) sets:
  - DOPUSH=0, DOUT=0, LOCKED=0, BIT_OFFSET=0, ERR=0, ERR_CNT=0, GOUND_CNT=0;
  - state=HUNT, prev=0, have_prev=0, hit_cnt=0, consec_err=0, expected=0.
- **Word window.**
  - On each DIVALID cycle: W = {DIN, prev} (64 bits), A(k) = W[k+31:k]. Then prev<=DIN and have_prev<=1.
  - With delay s, A(s) equals the previous sent word.
  - Non-DIVALID cycles: no state or counter change; DOPUSH=0, ERR=0.
- **States:** HUNT, CONFIRM, WORD_LOCK, CHECK.
- **HUNT** (requires have_prev=1):
  - Search k=0..31; the lowest k with A(k)==ALIGN_PAT wins.
  - On a hit: cand<=k, hit_cnt<=1. If ALIGN_HITS==1, go directly to WORD_LOCK; else go to CONFIRM.
  - No hit: stay in HUNT.
- **CONFIRM:**
  - A(cand)==ALIGN_PAT: hit_cnt++. When hit_cnt reaches ALIGN_HITS, set BIT_OFFSET<=cand and go to WORD_LOCK.
  - Otherwise go to HUNT with hit_cnt=0; the same word is not re-searched.
- **WORD_LOCK:**
  - A(BIT_OFFSET)==ALIGN_PAT: stay.
  - A==TRAIN_PAT or A==0: go to HUNT.
  - Any other value is the first data word: DOUT<=A, DOPUSH<=1, GOOD_CNT++, expected<=A+1 (mod 2^32), consec_err<=0, go to CHECK.
- **CHECK**, with A=A(BIT_OFFSET). Rules apply in this priority order:
  - A==expected: match. DOUT<=A, DOPUSH<=1, GOOD_CNT++, expected++, consec_err<=0. This includes A==0 when expected==0 (wrap).
  - A==TRAIN_PAT or A==0: end of burst. Go to HUNT, no error, LOCKED drops next cycle.
  - Otherwise mismatch: DOUT<=A, DOPUSH<=1, ERR<=1, ERR_CNT++ (saturating), expected<=A+1, consec_err++. When consec_err reaches MAX_CONSEC_ERR, go to HUNT.
- **Timing.** All outputs are registered: visible one cycle after the DIVALID cycle that completes the word. LOCKED follows the registered state.
- **Counters.** ERR_CNT and GOOD_CNT persist across re-locks; only RST/CLR clears them.
- **Reset mid-stream.** RST/CLR mid-stream drops everything. The first DIVALID afterwards only loads prev (have_prev=0 → no search).

Test Plan:
- **Lock at offset 0:** s=0; TRAIN_PAT×4, ALIGN_PAT×3, data 5,6,7,8, then TRAIN_PAT → BIT_OFFSET=0, LOCKED=1, DOUT 5,6,7,8 with DOPUSH, GOOD_CNT=4, ERR_CNT=0, then LOCKED=0.
- **Bit-rotated stream:** s=8, same stream → BIT_OFFSET=8, DOUT 5,6,7,8 one word behind raw input, GOOD_CNT=4.
- **Single corruption:** s=13; data 100,101,0xDEAD,103,104 → ERR pulse on 0xDEAD, ERR_CNT=1, mismatch on 103 (expected 0xDEAE) gives ERR_CNT=2, then 104 matches, still LOCKED.
- **Loss of lock:** 4 consecutive random words in CHECK → ERR_CNT+=4, back to HUNT, LOCKED=0.
- **False single marker:** s=3, one ALIGN_PAT then a random word (ALIGN_HITS=2) → no lock. Then ALIGN_PAT×2 → lock with BIT_OFFSET=3.
- **CLR and wrap:** CLR mid-CHECK → all outputs 0 next cycle. Re-lock with data 0xFFFFFFFE,0xFFFFFFFF,0,1 → 0 accepted as match, GOOD_CNT=4, no ERR.
